cmos_dvp_capture: RTL and testbench

//  Camera pixel-domain front end, downstream of the OV5640 I2C register loader. Holds off until the loader's
//  cfg_done, skips AE-settling frames, then samples the 8-bit DVP bus.

---
 rtl/cmos_cap_pkg.sv | 17 +
 rtl/cdc_sync_2ff.sv | 25 ++
 rtl/cmos_dvp_capture.sv | 186 ++++++++++++++++++
 tb/tb_cmos_dvp_capture.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/cmos_cap_pkg.sv
// Shared types and widths for the DVP capture front end.
//   state_t : capture FSM states
//   PIX_W   : packed pixel width (RGB565)
//   CNT_W   : width of frame / pixel / line counters
package cmos_cap_pkg;

  localparam int unsigned PIX_W = 16;
  localparam int unsigned CNT_W = 16;

  typedef enum logic [1:0] {
    WAIT_CFG = 2'd0,
    SKIP     = 2'd1,
    WAIT_VS  = 2'd2,
    ACTIVE   = 2'd3
  } state_t;

endpackage

// File: rtl/cdc_sync_2ff.sv
// Two-flop synchroniser for a single level signal from another clock domain.
//   clk_i : destination clock
//   rst_n : synchronous active-low reset, output resets to 0
//   din   : asynchronous level input
//   dout  : synchronised level
module cdc_sync_2ff (
  input  logic clk_i,
  input  logic rst_n,
  input  logic din,
  output logic dout
);

  logic meta;

  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      meta <= 1'b0;
      dout <= 1'b0;
    end else begin
      meta <= din;
      dout <= meta;
    end
  end

endmodule

// File: rtl/cmos_dvp_capture.sv
// OV5640 DVP capture front end. Waits for the register loader's cfg_done,
// discards SKIP_FRAMES frames, then packs DVP byte pairs into RGB565 pixels
// tagged with start-of-frame and end-of-line flags.
//   clk_i         camera PCLK
//   rst_n         synchronous active-low reset
//   cfg_done_i    loader done (asynchronous, synchronised here)
//   cam_hsize_i   expected pixels per line
//   cam_vsize_i   expected lines per frame
//   cmos_*_i      DVP vsync / href / data pins
//   pix_valid_o   pixel strobe; pix_data_o = {first byte, second byte}
//   pix_sof_o     first pixel of frame, pix_eol_o pixel at x == hsize-1
//   frame_cnt_o   output frames started (wrapping)
//   busy_o        FSM in ACTIVE
// Optional macro CMOS_CAP_FRAME_STAT_EN adds meas_hsize_o, meas_vsize_o and
// sticky size_err_o frame-size measurement outputs.
module cmos_dvp_capture
  import cmos_cap_pkg::*;
#(
  parameter logic [CNT_W-1:0] SKIP_FRAMES = 16'd10,
  parameter logic             VS_POL      = 1'b1,
  parameter logic             HS_POL      = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_n,
  input  logic             cfg_done_i,
  input  logic [CNT_W-1:0] cam_hsize_i,
  input  logic [CNT_W-1:0] cam_vsize_i,
  input  logic             cmos_vsync_i,
  input  logic             cmos_href_i,
  input  logic [7:0]       cmos_data_i,
  output logic             pix_valid_o,
  output logic [PIX_W-1:0] pix_data_o,
  output logic             pix_sof_o,
  output logic             pix_eol_o,
  output logic [CNT_W-1:0] frame_cnt_o,
  output logic             busy_o
`ifdef CMOS_CAP_FRAME_STAT_EN
  ,
  output logic [CNT_W-1:0] meas_hsize_o,
  output logic [CNT_W-1:0] meas_vsize_o,
  output logic             size_err_o
`endif
);

  logic             cfg_sync;
  logic             vs_r, hs_r, vs_q, hs_q;
  logic [7:0]       d_r;
  logic             boundary, hs_fall;
  logic             frame_start, pack_en;
  logic             phase, sof_arm, line_px;
  logic [7:0]       hi;
  logic [CNT_W-1:0] x, y, skip_cnt;
  state_t           state, state_nx;

  cdc_sync_2ff u_cfg_sync (
    .clk_i (clk_i),
    .rst_n (rst_n),
    .din   (cfg_done_i),
    .dout  (cfg_sync)
  );

  // vs_r / hs_r hold polarity-normalised "active" levels of the pins.
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      vs_r <= 1'b0;
      hs_r <= 1'b0;
      d_r  <= '0;
      vs_q <= 1'b0;
      hs_q <= 1'b0;
    end else begin
      vs_r <= (cmos_vsync_i == VS_POL);
      hs_r <= (cmos_href_i == HS_POL);
      d_r  <= cmos_data_i;
      vs_q <= vs_r;
      hs_q <= hs_r;
    end
  end

  assign boundary = vs_r & ~vs_q;
  assign hs_fall  = hs_q & ~hs_r;

  always_ff @(posedge clk_i) begin
    if (!rst_n) state <= WAIT_CFG;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      WAIT_CFG: if (cfg_sync) state_nx = (SKIP_FRAMES == '0) ? WAIT_VS : SKIP;
      SKIP:     if (boundary && (skip_cnt + 16'd1 == SKIP_FRAMES)) state_nx = WAIT_VS;
      WAIT_VS:  if (boundary) state_nx = ACTIVE;
      ACTIVE:   state_nx = ACTIVE;
      default:  state_nx = WAIT_CFG;
    endcase
    if (!cfg_sync) state_nx = WAIT_CFG;
  end

  // A boundary takes priority over packing, so a half-assembled pixel on
  // the boundary cycle is simply discarded by the phase reset.
  assign frame_start = cfg_sync && boundary && (state == WAIT_VS || state == ACTIVE);
  assign pack_en     = cfg_sync && (state == ACTIVE) && !boundary && hs_r;
  assign busy_o      = (state == ACTIVE);

`ifdef CMOS_CAP_FRAME_STAT_EN
  logic [CNT_W-1:0] last_px;
`else
  logic unused_vsize;
  assign unused_vsize = ^cam_vsize_i;
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      pix_valid_o <= 1'b0;
      pix_data_o  <= '0;
      pix_sof_o   <= 1'b0;
      pix_eol_o   <= 1'b0;
      frame_cnt_o <= '0;
      skip_cnt    <= '0;
      x           <= '0;
      y           <= '0;
      hi          <= '0;
      phase       <= 1'b0;
      sof_arm     <= 1'b0;
      line_px     <= 1'b0;
`ifdef CMOS_CAP_FRAME_STAT_EN
      last_px      <= '0;
      meas_hsize_o <= '0;
      meas_vsize_o <= '0;
      size_err_o   <= 1'b0;
`endif
    end else begin
      pix_valid_o <= 1'b0;
      pix_sof_o   <= 1'b0;
      pix_eol_o   <= 1'b0;

      if (state == WAIT_CFG)              skip_cnt <= '0;
      else if (state == SKIP && boundary) skip_cnt <= skip_cnt + 16'd1;

`ifdef CMOS_CAP_FRAME_STAT_EN
      if (state == WAIT_CFG) size_err_o <= 1'b0;
      if (frame_start && state == ACTIVE) begin
        meas_hsize_o <= last_px;
        meas_vsize_o <= y;
        if (last_px != cam_hsize_i || y != cam_vsize_i) size_err_o <= 1'b1;
      end
`endif

      if (frame_start) begin
        frame_cnt_o <= frame_cnt_o + 16'd1;
        x           <= '0;
        y           <= '0;
        sof_arm     <= 1'b1;
        phase       <= 1'b0;
        line_px     <= 1'b0;
      end else if (pack_en) begin
        if (!phase) begin
          hi    <= d_r;
          phase <= 1'b1;
        end else begin
          phase       <= 1'b0;
          pix_valid_o <= 1'b1;
          pix_data_o  <= {hi, d_r};
          pix_sof_o   <= sof_arm;
          sof_arm     <= 1'b0;
          pix_eol_o   <= (cam_hsize_i != '0) && (x == cam_hsize_i - 16'd1);
          if (x != '1) x <= x + 16'd1;
          line_px     <= 1'b1;
        end
      end else begin
        phase <= 1'b0;
        if (hs_fall) begin
          if (line_px) begin
            y <= y + 16'd1;
`ifdef CMOS_CAP_FRAME_STAT_EN
            last_px <= x;
`endif
          end
          x       <= '0;
          line_px <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_cmos_dvp_capture.sv
module tb_cmos_dvp_capture;
  import cmos_cap_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, cfg_done, vs, hs;
  logic [7:0]  d;
  logic [15:0] hsize, vsize;
  logic        pix_valid, pix_sof, pix_eol, busy;
  logic [15:0] pix_data, frame_cnt;
`ifdef CMOS_CAP_FRAME_STAT_EN
  logic [15:0] meas_h, meas_v;
  logic        size_err;
`endif

  always #5 clk = ~clk;

  cmos_dvp_capture #(
    .SKIP_FRAMES (16'd2),
    .VS_POL      (1'b1),
    .HS_POL      (1'b1)
  ) dut (
    .clk_i        (clk),
    .rst_n        (rst_n),
    .cfg_done_i   (cfg_done),
    .cam_hsize_i  (hsize),
    .cam_vsize_i  (vsize),
    .cmos_vsync_i (vs),
    .cmos_href_i  (hs),
    .cmos_data_i  (d),
    .pix_valid_o  (pix_valid),
    .pix_data_o   (pix_data),
    .pix_sof_o    (pix_sof),
    .pix_eol_o    (pix_eol),
    .frame_cnt_o  (frame_cnt),
    .busy_o       (busy)
`ifdef CMOS_CAP_FRAME_STAT_EN
    ,
    .meas_hsize_o (meas_h),
    .meas_vsize_o (meas_v),
    .size_err_o   (size_err)
`endif
  );

  typedef struct packed {
    logic [15:0] d;
    logic        sof;
    logic        eol;
  } px_t;

  px_t pq[$];
  int  n_chk  = 0;
  int  n_pass = 0;

  always @(posedge clk) begin
    #1;
    if (pix_valid === 1'b1) pq.push_back({pix_data, pix_sof, pix_eol});
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic expect_px(input int i, input logic [15:0] dd, input logic s, input logic e);
    px_t want;
    want = {dd, s, e};
    if (i < pq.size()) chk($sformatf("px%0d", i), 32'(pq[i]), 32'(want));
    else               chk($sformatf("px%0d_missing", i), pq.size(), i + 1);
  endtask

  // Pins change on the falling edge, one DVP cycle per call.
  task automatic pin(input logic v, input logic h, input logic [7:0] b);
    vs = v; hs = h; d = b;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) pin(1'b0, 1'b0, 8'h00);
  endtask

  task automatic vs_pulse();
    for (int i = 0; i < 3; i++) pin(1'b1, 1'b0, 8'h00);
    idle(3);
  endtask

  task automatic line(input int n, input logic [7:0] start);
    for (int i = 0; i < n; i++) pin(1'b0, 1'b1, start + 8'(i));
    idle(4);
  endtask

  task automatic frame_4x2(input logic [7:0] start);
    vs_pulse();
    line(8, start);
    line(8, start + 8'd8);
    idle(4);
  endtask

  initial begin
    rst_n = 1'b0; cfg_done = 1'b0; vs = 1'b0; hs = 1'b0; d = 8'h00;
    hsize = 16'd4; vsize = 16'd2;
    @(negedge clk);
    idle(4);
    rst_n = 1'b1;
    idle(1);
    chk("rst_valid", pix_valid, 0);
    chk("rst_data", pix_data, 0);
    chk("rst_sof_eol", {pix_sof, pix_eol}, 0);
    chk("rst_fcnt", frame_cnt, 0);
    chk("rst_busy", busy, 0);

    // No cfg_done: nothing comes out
    for (int f = 0; f < 3; f++) frame_4x2(8'h00);
    chk("nocfg_pix", pq.size(), 0);
    chk("nocfg_fcnt", frame_cnt, 0);
    chk("nocfg_busy", busy, 0);

    // Two skipped frames, third is output
    cfg_done = 1'b1;
    idle(5);
    frame_4x2(8'h00);
    frame_4x2(8'h00);
    chk("skip_pix", pq.size(), 0);
    chk("skip_fcnt", frame_cnt, 0);
    frame_4x2(8'h00);
    chk("f3_count", pq.size(), 8);
    expect_px(0, 16'h0001, 1'b1, 1'b0);
    expect_px(1, 16'h0203, 1'b0, 1'b0);
    expect_px(3, 16'h0607, 1'b0, 1'b1);
    expect_px(4, 16'h0809, 1'b0, 1'b0);
    expect_px(7, 16'h0E0F, 1'b0, 1'b1);
    chk("f3_fcnt", frame_cnt, 1);
    chk("f3_busy", busy, 1);

    // Odd byte count line: 9th byte dropped, next line pairs correctly
    pq.delete();
    vs_pulse();
    line(9, 8'h10);
    line(8, 8'h20);
    chk("odd_count", pq.size(), 8);
    expect_px(0, 16'h1011, 1'b1, 1'b0);
    expect_px(3, 16'h1617, 1'b0, 1'b1);
    expect_px(4, 16'h2021, 1'b0, 1'b0);
    expect_px(7, 16'h2627, 1'b0, 1'b1);
    chk("odd_fcnt", frame_cnt, 2);

    // Boundary while href active at phase 1
    pq.delete();
    pin(1'b0, 1'b1, 8'hA0);
    pin(1'b0, 1'b1, 8'hA1);
    pin(1'b0, 1'b1, 8'hA2);
    pin(1'b1, 1'b1, 8'hA3);
    pin(1'b1, 1'b0, 8'h00);
    pin(1'b1, 1'b0, 8'h00);
    idle(3);
    line(8, 8'hB0);
    line(8, 8'hB8);
    idle(4);
    chk("bnd_count", pq.size(), 9);
    expect_px(0, 16'hA0A1, 1'b0, 1'b0);
    expect_px(1, 16'hB0B1, 1'b1, 1'b0);
    expect_px(4, 16'hB6B7, 1'b0, 1'b1);
    expect_px(8, 16'hBEBF, 1'b0, 1'b1);
    chk("bnd_fcnt", frame_cnt, 3);
`ifdef CMOS_CAP_FRAME_STAT_EN
    chk("bnd_meas_h", meas_h, 4);
    chk("bnd_meas_v", meas_v, 2);
    chk("bnd_err", size_err, 0);
`endif

    // Oversize 6x3 frame: extra pixels without eol
    pq.delete();
    vs_pulse();
    line(12, 8'h40);
    line(12, 8'h4C);
    line(12, 8'h58);
    idle(4);
    chk("big_count", pq.size(), 18);
    expect_px(3, 16'h4647, 1'b0, 1'b1);
    expect_px(4, 16'h4849, 1'b0, 1'b0);
    expect_px(6, 16'h4C4D, 1'b0, 1'b0);
    expect_px(9, 16'h5253, 1'b0, 1'b1);
    frame_4x2(8'h70);
`ifdef CMOS_CAP_FRAME_STAT_EN
    chk("big_meas_h", meas_h, 6);
    chk("big_meas_v", meas_v, 3);
    chk("big_err", size_err, 1);
`endif
    frame_4x2(8'h80);
    chk("pre_drop_fcnt", frame_cnt, 6);
`ifdef CMOS_CAP_FRAME_STAT_EN
    chk("ok_meas_h", meas_h, 4);
    chk("sticky_err", size_err, 1);
`endif

    // cfg_done dropped mid-line
    for (int i = 0; i < 3; i++) pin(1'b0, 1'b1, 8'hC0 + 8'(i));
    cfg_done = 1'b0;
    for (int i = 0; i < 4; i++) pin(1'b0, 1'b1, 8'hC3 + 8'(i));
    pq.delete();
    for (int i = 0; i < 10; i++) pin(1'b0, 1'b1, 8'hD0 + 8'(i));
    idle(4);
    chk("drop_pix", pq.size(), 0);
    chk("drop_busy", busy, 0);
    chk("drop_fcnt", frame_cnt, 6);
`ifdef CMOS_CAP_FRAME_STAT_EN
    chk("drop_err_clr", size_err, 0);
`endif

    // Re-assert: skip sequence repeats, frame count continues
    cfg_done = 1'b1;
    idle(5);
    frame_4x2(8'h00);
    frame_4x2(8'h00);
    chk("reskip_pix", pq.size(), 0);
    frame_4x2(8'h30);
    chk("re_count", pq.size(), 8);
    expect_px(0, 16'h3031, 1'b1, 1'b0);
    expect_px(7, 16'h3E3F, 1'b0, 1'b1);
    chk("re_fcnt", frame_cnt, 7);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
